// File: rtl/rob_dispatch_pkg.sv
// Shared constants and types for the dispatch/rename stage feeding the reorder buffer.
package rob_dispatch_pkg;

  localparam int unsigned DATA_WIDTH = 70;
  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned TAG_W      = 32;
  localparam int unsigned REG_W      = 5;
  localparam int unsigned NREGS      = 32;
  localparam int unsigned NSLOT      = 4;
  localparam int unsigned NCOMMIT    = 2;

  localparam int unsigned FLAG_BIT = 69;
  localparam int unsigned TAG_HI   = 68;
  localparam int unsigned TAG_LO   = 37;
  localparam int unsigned DST_HI   = 36;
  localparam int unsigned DST_LO   = 32;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } rat_entry;

  // ROB slot addressed by a tag.
  function automatic logic [ADDR_WIDTH-1:0] slot_of(input logic [TAG_W-1:0] tag);
    return tag[ADDR_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/rob_dispatch_if.sv
// Dispatch, ROB write, rename, branch and commit signals of the dispatch stage.
interface rob_dispatch_if;
  import rob_dispatch_pkg::*;

  logic [NSLOT-1:0]      in_valid;
  logic [NSLOT-1:0]      in_wr;
  logic [REG_W-1:0]      in_dst  [NSLOT];
  logic [REG_W-1:0]      in_srcA [NSLOT];
  logic [REG_W-1:0]      in_srcB [NSLOT];
  logic                  in_ready;
  logic [NSLOT-1:0]      rob_full;
  logic                  rob_wen;
  logic [1:0]            rob_we;
  logic [DATA_WIDTH-1:0] rob_in  [NSLOT];
  logic [TAG_W-1:0]      out_tag [NSLOT];
  logic [TAG_W-1:0]      out_tA  [NSLOT];
  logic [TAG_W-1:0]      out_tB  [NSLOT];
  logic [NSLOT-1:0]      out_tAv;
  logic [NSLOT-1:0]      out_tBv;
  logic                  branch;
  logic [TAG_W-1:0]      branch_tag;
  logic [NCOMMIT-1:0]    commit_valid;
  logic [TAG_W-1:0]      commit_tag [NCOMMIT];
  logic [REG_W-1:0]      commit_dst [NCOMMIT];

  modport master (
    output in_valid, in_wr, in_dst, in_srcA, in_srcB, rob_full,
           branch, branch_tag, commit_valid, commit_tag, commit_dst,
    input  in_ready, rob_wen, rob_we, rob_in, out_tag, out_tA, out_tB, out_tAv, out_tBv
  );

  modport slave (
    input  in_valid, in_wr, in_dst, in_srcA, in_srcB, rob_full,
           branch, branch_tag, commit_valid, commit_tag, commit_dst,
    output in_ready, rob_wen, rob_we, rob_in, out_tag, out_tA, out_tB, out_tAv, out_tBv
  );

endinterface

// File: rtl/rob_rat.sv
// Register alias table: per-register youngest producer tag, with commit clear and branch squash.
module rob_rat
  import rob_dispatch_pkg::*;
(
  input  logic               wclk,
  input  logic               rst,
  input  logic [REG_W-1:0]   rd_a_reg [NSLOT],
  input  logic [REG_W-1:0]   rd_b_reg [NSLOT],
  output rat_entry           rd_a_c   [NSLOT],
  output rat_entry           rd_b_c   [NSLOT],
  input  logic [NSLOT-1:0]   wr_en,
  input  logic [REG_W-1:0]   wr_reg   [NSLOT],
  input  logic [TAG_W-1:0]   wr_tag   [NSLOT],
  input  logic [NCOMMIT-1:0] clr_en,
  input  logic [REG_W-1:0]   clr_reg  [NCOMMIT],
  input  logic [TAG_W-1:0]   clr_tag  [NCOMMIT],
  input  logic               squash,
  input  logic [TAG_W-1:0]   squash_tag
);

  rat_entry rat_q [NREGS];
  rat_entry rat_d [NREGS];

  // Register 0 is hardwired to the architectural file.
  always_comb begin
    for (int k = 0; k < NSLOT; k++) begin
      rd_a_c[k] = (rd_a_reg[k] == '0) ? '0 : rat_q[rd_a_reg[k]];
      rd_b_c[k] = (rd_b_reg[k] == '0) ? '0 : rat_q[rd_b_reg[k]];
    end
  end

  // Squash and commit compare against the current table; dispatch writes land last so they win.
  always_comb begin
    rat_d = rat_q;
    if (squash) begin
      for (int r = 0; r < NREGS; r++) begin
        if (rat_q[r].valid && (rat_q[r].tag > squash_tag)) rat_d[r].valid = 1'b0;
      end
    end
    for (int i = 0; i < NCOMMIT; i++) begin
      if (clr_en[i] && (rat_q[clr_reg[i]].tag == clr_tag[i])) rat_d[clr_reg[i]].valid = 1'b0;
    end
    for (int k = 0; k < NSLOT; k++) begin
      if (wr_en[k]) rat_d[wr_reg[k]] = '{valid: 1'b1, tag: wr_tag[k]};
    end
  end

  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) rat_q[r] <= '0;
    end else begin
      rat_q <= rat_d;
    end
  end

endmodule

// File: rtl/rob_dispatch.sv
// Dispatch/rename stage: accepts up to four instructions, allocates tags, writes ROB entries, renames sources.
module rob_dispatch
  import rob_dispatch_pkg::*;
(
  input  logic           wclk,
  input  logic           rst,
  rob_dispatch_if.slave  dif
);

  logic                  rob_wen_q, rob_wen_d;
  logic [1:0]            rob_we_q, rob_we_d;
  logic [DATA_WIDTH-1:0] rob_in_q  [NSLOT];
  logic [DATA_WIDTH-1:0] rob_in_d  [NSLOT];
  logic [TAG_W-1:0]      out_tag_q [NSLOT];
  logic [TAG_W-1:0]      out_tag_d [NSLOT];
  logic [TAG_W-1:0]      out_ta_q  [NSLOT];
  logic [TAG_W-1:0]      out_ta_d  [NSLOT];
  logic [TAG_W-1:0]      out_tb_q  [NSLOT];
  logic [TAG_W-1:0]      out_tb_d  [NSLOT];
  logic [NSLOT-1:0]      out_tav_q, out_tav_d, out_tbv_q, out_tbv_d;
  logic [TAG_W-1:0]      next_tag_q, next_tag_d;

  logic                  legal_c, full_c, accept_c;
  logic [2:0]            n_c;
  logic [1:0]            we_c;
  logic [TAG_W-1:0]      slot_tag_c [NSLOT];
  rat_entry              rat_a_c [NSLOT];
  rat_entry              rat_b_c [NSLOT];
  rat_entry              src_a_c [NSLOT];
  rat_entry              src_b_c [NSLOT];
  logic [NSLOT-1:0]      wr_en_c;

  // Only contiguous low-aligned groups are legal; each size checks its own ROB-full level.
  always_comb begin
    legal_c = 1'b1;
    n_c     = 3'd0;
    we_c    = 2'd0;
    full_c  = 1'b1;
    case (dif.in_valid)
      4'b0001: begin n_c = 3'd1; we_c = 2'd0; full_c = dif.rob_full[0]; end
      4'b0011: begin n_c = 3'd2; we_c = 2'd1; full_c = dif.rob_full[1]; end
      4'b0111: begin n_c = 3'd3; we_c = 2'd2; full_c = dif.rob_full[2]; end
      4'b1111: begin n_c = 3'd4; we_c = 2'd3; full_c = dif.rob_full[3]; end
      default: legal_c = 1'b0;
    endcase
    accept_c = legal_c && !dif.branch && !full_c;
  end

  assign dif.in_ready = accept_c;

  // Rename: RAT value, overridden by the youngest earlier writer in the same group.
  always_comb begin
    for (int k = 0; k < NSLOT; k++) begin
      slot_tag_c[k] = next_tag_q + TAG_W'(k);
      wr_en_c[k]    = accept_c && dif.in_valid[k] && dif.in_wr[k] && (dif.in_dst[k] != '0);
      src_a_c[k]    = rat_a_c[k].valid ? rat_a_c[k] : '0;
      src_b_c[k]    = rat_b_c[k].valid ? rat_b_c[k] : '0;
    end
    for (int k = 1; k < NSLOT; k++) begin
      for (int j = 0; j < k; j++) begin
        if (dif.in_valid[j] && dif.in_wr[j] && (dif.in_dst[j] != '0)) begin
          if (dif.in_dst[j] == dif.in_srcA[k]) src_a_c[k] = '{valid: 1'b1, tag: slot_tag_c[j]};
          if (dif.in_dst[j] == dif.in_srcB[k]) src_b_c[k] = '{valid: 1'b1, tag: slot_tag_c[j]};
        end
      end
    end
  end

  rob_rat u_rat (
    .wclk       (wclk),
    .rst        (rst),
    .rd_a_reg   (dif.in_srcA),
    .rd_b_reg   (dif.in_srcB),
    .rd_a_c     (rat_a_c),
    .rd_b_c     (rat_b_c),
    .wr_en      (wr_en_c),
    .wr_reg     (dif.in_dst),
    .wr_tag     (slot_tag_c),
    .clr_en     (dif.commit_valid),
    .clr_reg    (dif.commit_dst),
    .clr_tag    (dif.commit_tag),
    .squash     (dif.branch),
    .squash_tag (dif.branch_tag)
  );

  // Output registers hold unless a group is accepted; unused slots clear on accept.
  always_comb begin
    rob_wen_d  = accept_c;
    rob_we_d   = rob_we_q;
    rob_in_d   = rob_in_q;
    out_tag_d  = out_tag_q;
    out_ta_d   = out_ta_q;
    out_tb_d   = out_tb_q;
    out_tav_d  = out_tav_q;
    out_tbv_d  = out_tbv_q;
    next_tag_d = next_tag_q;
    if (accept_c) begin
      rob_we_d   = we_c;
      next_tag_d = next_tag_q + TAG_W'(n_c);
      for (int k = 0; k < NSLOT; k++) begin
        rob_in_d[k]  = '0;
        out_tag_d[k] = '0;
        out_ta_d[k]  = '0;
        out_tb_d[k]  = '0;
        out_tav_d[k] = 1'b0;
        out_tbv_d[k] = 1'b0;
        if (dif.in_valid[k]) begin
          rob_in_d[k][FLAG_BIT]      = 1'b1;
          rob_in_d[k][TAG_HI:TAG_LO] = slot_tag_c[k];
          rob_in_d[k][DST_HI:DST_LO] = dif.in_dst[k];
          out_tag_d[k] = slot_tag_c[k];
          out_ta_d[k]  = src_a_c[k].tag;
          out_tb_d[k]  = src_b_c[k].tag;
          out_tav_d[k] = src_a_c[k].valid;
          out_tbv_d[k] = src_b_c[k].valid;
        end
      end
    end
  end

  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      rob_wen_q  <= 1'b0;
      rob_we_q   <= '0;
      out_tav_q  <= '0;
      out_tbv_q  <= '0;
      next_tag_q <= '0;
      for (int k = 0; k < NSLOT; k++) begin
        rob_in_q[k]  <= '0;
        out_tag_q[k] <= '0;
        out_ta_q[k]  <= '0;
        out_tb_q[k]  <= '0;
      end
    end else begin
      rob_wen_q  <= rob_wen_d;
      rob_we_q   <= rob_we_d;
      rob_in_q   <= rob_in_d;
      out_tag_q  <= out_tag_d;
      out_ta_q   <= out_ta_d;
      out_tb_q   <= out_tb_d;
      out_tav_q  <= out_tav_d;
      out_tbv_q  <= out_tbv_d;
      next_tag_q <= next_tag_d;
    end
  end

  assign dif.rob_wen = rob_wen_q;
  assign dif.rob_we  = rob_we_q;
  assign dif.rob_in  = rob_in_q;
  assign dif.out_tag = out_tag_q;
  assign dif.out_tA  = out_ta_q;
  assign dif.out_tB  = out_tb_q;
  assign dif.out_tAv = out_tav_q;
  assign dif.out_tBv = out_tbv_q;

endmodule

// File: tb/tb_rob_dispatch.sv
// Directed bench for rob_dispatch with hand-computed tags, ROB entries and rename results.
module tb_rob_dispatch;
  import rob_dispatch_pkg::*;

  logic wclk = 1'b0;
  logic rst  = 1'b1;

  rob_dispatch_if dif ();

  rob_dispatch dut (
    .wclk (wclk),
    .rst  (rst),
    .dif  (dif)
  );

  always #5 wclk = ~wclk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [DATA_WIDTH-1:0] got,
                          input logic [DATA_WIDTH-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    dif.in_valid     = '0;
    dif.in_wr        = '0;
    dif.rob_full     = '0;
    dif.branch       = 1'b0;
    dif.branch_tag   = '0;
    dif.commit_valid = '0;
    for (int k = 0; k < NSLOT; k++) begin
      dif.in_dst[k]  = '0;
      dif.in_srcA[k] = '0;
      dif.in_srcB[k] = '0;
    end
    for (int i = 0; i < NCOMMIT; i++) begin
      dif.commit_tag[i] = '0;
      dif.commit_dst[i] = '0;
    end
  endtask

  // Register fields packed as {slot3, slot2, slot1, slot0}.
  task automatic grp(input logic [3:0] v, input logic [3:0] w, input logic [19:0] d,
                     input logic [19:0] a, input logic [19:0] b);
    idle();
    dif.in_valid = v;
    dif.in_wr    = w;
    for (int k = 0; k < NSLOT; k++) begin
      dif.in_dst[k]  = d[k*5 +: 5];
      dif.in_srcA[k] = a[k*5 +: 5];
      dif.in_srcB[k] = b[k*5 +: 5];
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  initial begin
    idle();
    #12;
    check_eq("rst_wen",   70'(dif.rob_wen),    70'd0);
    check_eq("rst_we",    70'(dif.rob_we),     70'd0);
    check_eq("rst_in0",   dif.rob_in[0],       70'd0);
    check_eq("rst_tag0",  70'(dif.out_tag[0]), 70'd0);
    check_eq("rst_tav",   70'(dif.out_tAv),    70'd0);
    @(negedge wclk);
    rst = 1'b0;
    tick();

    // two-wide group writing r3/r4: tags 0,1
    grp(4'b0011, 4'b0011, {5'd0, 5'd0, 5'd4, 5'd3}, 20'd0, 20'd0);
    #1 check_eq("a_ready", 70'(dif.in_ready), 70'd1);
    tick();
    check_eq("a_wen",  70'(dif.rob_wen), 70'd1);
    check_eq("a_we",   70'(dif.rob_we),  70'd1);
    check_eq("a_in0",  dif.rob_in[0], {1'b1, 32'd0, 5'd3, 32'd0});
    check_eq("a_in1",  dif.rob_in[1], {1'b1, 32'd1, 5'd4, 32'd0});
    check_eq("a_in2",  dif.rob_in[2], 70'd0);
    check_eq("a_tag1", 70'(dif.out_tag[1]), 70'd1);

    idle();
    #1 check_eq("idle_ready", 70'(dif.in_ready), 70'd0);
    tick();
    check_eq("idle_wen",  70'(dif.rob_wen),    70'd0);
    check_eq("idle_hold", 70'(dif.out_tag[1]), 70'd1);

    // slot0 writes r5, slot1 reads r5 (bypass); srcA0=r3 and srcB1=r4 from RAT
    grp(4'b0011, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd5}, {5'd0, 5'd0, 5'd5, 5'd3}, {5'd0, 5'd0, 5'd4, 5'd0});
    tick();
    check_eq("b_tag0", 70'(dif.out_tag[0]), 70'd2);
    check_eq("b_tA1",  70'(dif.out_tA[1]),  70'd2);
    check_eq("b_tAv",  70'(dif.out_tAv),    70'b0011);
    check_eq("b_tB1",  70'(dif.out_tB[1]),  70'd1);
    check_eq("b_tBv",  70'(dif.out_tBv),    70'b0010);

    // later group reads r5 from the RAT
    grp(4'b0001, 4'b0000, 20'd0, {5'd0, 5'd0, 5'd0, 5'd5}, 20'd0);
    tick();
    check_eq("c_tag0", 70'(dif.out_tag[0]), 70'd4);
    check_eq("c_tA0",  70'(dif.out_tA[0]),  70'd2);
    check_eq("c_tAv",  70'(dif.out_tAv),    70'b0001);
    check_eq("c_we",   70'(dif.rob_we),     70'd0);
    check_eq("c_in1",  dif.rob_in[1],       70'd0);

    // rob_full[2] blocks a 3-wide group but not a 2-wide one
    grp(4'b0111, 4'b0000, 20'd0, 20'd0, 20'd0);
    dif.rob_full = 4'b0100;
    #1 check_eq("full_ready", 70'(dif.in_ready), 70'd0);
    tick();
    check_eq("full_wen", 70'(dif.rob_wen), 70'd0);
    grp(4'b0011, 4'b0000, 20'd0, 20'd0, 20'd0);
    dif.rob_full = 4'b0100;
    #1 check_eq("full2_ready", 70'(dif.in_ready), 70'd1);
    tick();
    check_eq("full2_tag0", 70'(dif.out_tag[0]), 70'd5);
    check_eq("full2_we",   70'(dif.rob_we),     70'd1);

    // tags 7..9, then 10..13 mapping r1..r4
    grp(4'b0111, 4'b0000, 20'd0, 20'd0, 20'd0);
    tick();
    check_eq("e_tag2", 70'(dif.out_tag[2]), 70'd9);
    grp(4'b1111, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 20'd0, 20'd0);
    tick();
    check_eq("e_we",   70'(dif.rob_we),     70'd3);
    check_eq("e_in3",  dif.rob_in[3],       {1'b1, 32'd13, 5'd4, 32'd0});
    check_eq("e_slot", 70'(slot_of(dif.out_tag[3])), 70'd13);

    // mispredict at tag 11: group that cycle is rejected
    grp(4'b0001, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd7}, 20'd0, 20'd0);
    dif.branch     = 1'b1;
    dif.branch_tag = 32'd11;
    #1 check_eq("br_ready", 70'(dif.in_ready), 70'd0);
    tick();
    check_eq("br_wen", 70'(dif.rob_wen), 70'd0);
    grp(4'b1111, 4'b0000, 20'd0, {5'd4, 5'd3, 5'd2, 5'd1}, {5'd0, 5'd0, 5'd0, 5'd7});
    tick();
    check_eq("br_tag0", 70'(dif.out_tag[0]), 70'd14);
    check_eq("br_tAv",  70'(dif.out_tAv),    70'b0011);
    check_eq("br_tA0",  70'(dif.out_tA[0]),  70'd10);
    check_eq("br_tA1",  70'(dif.out_tA[1]),  70'd11);
    check_eq("br_tBv",  70'(dif.out_tBv),    70'd0);

    // commit r1/tag10 retires; stale r2/tag7 leaves tag 11 mapped
    idle();
    dif.commit_valid  = 2'b11;
    dif.commit_tag[0] = 32'd10;
    dif.commit_dst[0] = 5'd1;
    dif.commit_tag[1] = 32'd7;
    dif.commit_dst[1] = 5'd2;
    tick();
    grp(4'b0011, 4'b0000, 20'd0, {5'd0, 5'd0, 5'd2, 5'd1}, 20'd0);
    tick();
    check_eq("cm_tag0", 70'(dif.out_tag[0]), 70'd18);
    check_eq("cm_tAv",  70'(dif.out_tAv),    70'b0010);
    check_eq("cm_tA1",  70'(dif.out_tA[1]),  70'd11);

    // commit of r2/tag11 alongside a dispatch write to r2: dispatch wins
    grp(4'b0001, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd2}, 20'd0, 20'd0);
    dif.commit_valid  = 2'b01;
    dif.commit_tag[0] = 32'd11;
    dif.commit_dst[0] = 5'd2;
    tick();
    check_eq("cw_tag0", 70'(dif.out_tag[0]), 70'd20);
    grp(4'b0001, 4'b0000, 20'd0, {5'd0, 5'd0, 5'd0, 5'd2}, 20'd0);
    tick();
    check_eq("cw_tA0", 70'(dif.out_tA[0]), 70'd20);
    check_eq("cw_tAv", 70'(dif.out_tAv),   70'b0001);

    // register 0 is never renamed
    grp(4'b0011, 4'b0001, 20'd0, 20'd0, 20'd0);
    tick();
    check_eq("r0_tag1", 70'(dif.out_tag[1]), 70'd23);
    check_eq("r0_tAv",  70'(dif.out_tAv),    70'd0);

    // illegal non-contiguous pattern
    grp(4'b0101, 4'b0000, 20'd0, 20'd0, 20'd0);
    #1 check_eq("ill_ready", 70'(dif.in_ready), 70'd0);
    tick();
    check_eq("ill_wen", 70'(dif.rob_wen), 70'd0);

    // two writers of r6 in one group: youngest wins for bypass and RAT
    grp(4'b0111, 4'b0011, {5'd0, 5'd0, 5'd6, 5'd6}, {5'd0, 5'd6, 5'd0, 5'd0}, 20'd0);
    tick();
    check_eq("y_tag2", 70'(dif.out_tag[2]), 70'd26);
    check_eq("y_tA2",  70'(dif.out_tA[2]),  70'd25);
    check_eq("y_tAv",  70'(dif.out_tAv),    70'b0100);
    grp(4'b0001, 4'b0000, 20'd0, {5'd0, 5'd0, 5'd0, 5'd6}, 20'd0);
    tick();
    check_eq("y_rat", 70'(dif.out_tA[0]), 70'd25);

    // reset mid-stream clears outputs, tag counter and RAT
    grp(4'b0001, 4'b0000, 20'd0, {5'd0, 5'd0, 5'd0, 5'd6}, 20'd0);
    tick();
    check_eq("pre_tag0", 70'(dif.out_tag[0]), 70'd28);
    #2 rst = 1'b1;
    #1;
    check_eq("mr_wen",  70'(dif.rob_wen),    70'd0);
    check_eq("mr_tag0", 70'(dif.out_tag[0]), 70'd0);
    check_eq("mr_in0",  dif.rob_in[0],       70'd0);
    check_eq("mr_tav",  70'(dif.out_tAv),    70'd0);
    idle();
    @(negedge wclk);
    rst = 1'b0;
    grp(4'b0001, 4'b0000, 20'd0, {5'd0, 5'd0, 5'd0, 5'd6}, 20'd0);
    tick();
    check_eq("ar_tag0", 70'(dif.out_tag[0]), 70'd0);
    check_eq("ar_tAv",  70'(dif.out_tAv),    70'd0);
    check_eq("ar_in0",  dif.rob_in[0],       {1'b1, 69'd0});
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
